// File: rtl/stream_mux_rr_pkg.sv
// Shared defaults for the round-robin stream multiplexer and its arbiter.
package stream_mux_rr_pkg;

    localparam int unsigned DEFAULT_NUM_ELEM   = 4;
    localparam int unsigned DEFAULT_ELEM_WIDTH = 8;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from the pointer, wrapping from NUM_ELEM-1 back to 0.
// Produces both a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int unsigned NUM_ELEM = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_ELEM)
) (
    input  logic [NUM_ELEM-1:0] req,
    input  logic [IDX_W-1:0]    pointer,
    output logic [NUM_ELEM-1:0] gnt,
    output logic [IDX_W-1:0]    gnt_idx
);

    // Walk the requesters starting at the pointer and take the first hit.
    always_comb begin
        logic found;
        int   cand;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < int'(NUM_ELEM); i++) begin
            cand = int'(pointer) + i;
            if (cand >= int'(NUM_ELEM)) begin
                cand = cand - int'(NUM_ELEM);
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with round-robin arbitration and
// packet lock. Once a source starts a packet it owns the output until it
// delivers its last beat; the round-robin pointer moves only at packet end.
// The output beat is registered, and the register reloads whenever it is
// empty or being drained, giving one beat per cycle.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int unsigned NUM_ELEM   = DEFAULT_NUM_ELEM,
    parameter int unsigned ELEM_WIDTH = DEFAULT_ELEM_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] i_data_i,
    input  logic [NUM_ELEM-1:0]                 i_valid_i,
    input  logic [NUM_ELEM-1:0]                 i_last_i,
    output logic [NUM_ELEM-1:0]                 i_ready_o,
    output logic [ELEM_WIDTH-1:0]               o_data_o,
    output logic [$clog2(NUM_ELEM)-1:0]         o_idx_o,
    output logic                                o_last_o,
    output logic                                o_valid_o,
    input  logic                                o_ready_i
);

    localparam int unsigned IDX_W = $clog2(NUM_ELEM);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_e;

    lock_state_e         state;
    lock_state_e         state_next;
    logic [IDX_W-1:0]    lock_idx;
    logic [IDX_W-1:0]    lock_idx_next;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    rr_ptr_next;
    logic [NUM_ELEM-1:0] arb_req;
    logic [NUM_ELEM-1:0] gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                load;
    logic                accept;
    logic                sel_last;

    rr_arbiter #(
        .NUM_ELEM (NUM_ELEM)
    ) u_arbiter (
        .req     (arb_req),
        .pointer (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign load     = !o_valid_o || o_ready_i;
    assign accept   = load && (|gnt);
    assign sel_last = i_last_i[gnt_idx];

    // Reset is folded in so no source sees ready while the block is held in reset.
    assign i_ready_o = (load && arst_ni) ? gnt : '0;

    // Lock state, locked source and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state    <= UNLOCKED;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_next;
            lock_idx <= lock_idx_next;
            rr_ptr   <= rr_ptr_next;
        end
    end

    // A non-last beat locks onto its source; a last beat unlocks and advances the pointer.
    always_comb begin
        state_next    = state;
        lock_idx_next = lock_idx;
        rr_ptr_next   = rr_ptr;
        if (accept) begin
            if (sel_last) begin
                state_next  = UNLOCKED;
                rr_ptr_next = (gnt_idx == IDX_W'(NUM_ELEM - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end else begin
                state_next    = LOCKED;
                lock_idx_next = gnt_idx;
            end
        end
    end

    // While locked only the owning source may request, so others never interleave.
    always_comb begin
        arb_req = i_valid_i;
        if (state == LOCKED) begin
            arb_req = i_valid_i & ({{(NUM_ELEM-1){1'b0}}, 1'b1} << lock_idx);
        end
    end

    // Output register: reloads when empty or draining, otherwise holds its beat.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            o_valid_o <= 1'b0;
            o_data_o  <= '0;
            o_idx_o   <= '0;
            o_last_o  <= 1'b0;
        end else if (load) begin
            o_valid_o <= |gnt;
            if (|gnt) begin
                o_data_o <= i_data_i[gnt_idx];
                o_idx_o  <= gnt_idx;
                o_last_o <= sel_last;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: a 4-input instance driven from a
// vector table with an output-beat scoreboard, plus hand-written reset and
// 6-input wrap-around sequences.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            arst_n;
    logic [3:0][7:0] i_data;
    logic [3:0]      i_valid;
    logic [3:0]      i_last;
    logic [3:0]      i_ready;
    logic [7:0]      o_data;
    logic [1:0]      o_idx;
    logic            o_last;
    logic            o_valid;
    logic            o_ready;

    logic [5:0][7:0] d6;
    logic [5:0]      v6;
    logic [5:0]      l6;
    logic [5:0]      r6;
    logic [7:0]      od6;
    logic [2:0]      oi6;
    logic            ol6;
    logic            ov6;
    logic            ordy6;

    stream_mux_rr #(.NUM_ELEM(4), .ELEM_WIDTH(8)) dut (
        .clk_i     (clk),
        .arst_ni   (arst_n),
        .i_data_i  (i_data),
        .i_valid_i (i_valid),
        .i_last_i  (i_last),
        .i_ready_o (i_ready),
        .o_data_o  (o_data),
        .o_idx_o   (o_idx),
        .o_last_o  (o_last),
        .o_valid_o (o_valid),
        .o_ready_i (o_ready)
    );

    stream_mux_rr #(.NUM_ELEM(6), .ELEM_WIDTH(8)) dut6 (
        .clk_i     (clk),
        .arst_ni   (arst_n),
        .i_data_i  (d6),
        .i_valid_i (v6),
        .i_last_i  (l6),
        .i_ready_o (r6),
        .o_data_o  (od6),
        .o_idx_o   (oi6),
        .o_last_o  (ol6),
        .o_valid_o (ov6),
        .o_ready_i (ordy6)
    );

    typedef struct {
        logic [3:0]      valid;
        logic [3:0]      last;
        logic [3:0][7:0] din;
        logic            oready;
        logic [3:0]      exp_ready;
        logic            exp_ovalid;
        logic            chk_data;
        logic [7:0]      exp_data;
        logic            discard;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    beat_t sb[$];
    vec_t  vecs[$];
    int    vec_count   = 0;
    int    miscompares = 0;

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last,
                                input logic oready, input logic [3:0] exp_ready,
                                input logic exp_ovalid);
        vec_t v;
        v.valid      = valid;
        v.last       = last;
        v.din        = {8'h13, 8'h12, 8'h11, 8'h10};
        v.oready     = oready;
        v.exp_ready  = exp_ready;
        v.exp_ovalid = exp_ovalid;
        v.chk_data   = 1'b0;
        v.exp_data   = 8'h00;
        v.discard    = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record the beats the bench expects to be accepted.
    task automatic applyStimulus(input vec_t v);
        beat_t b;
        i_valid = v.valid;
        i_last  = v.last;
        i_data  = v.din;
        o_ready = v.oready;
        if (!v.discard) begin
            for (int k = 0; k < 4; k++) begin
                if (v.exp_ready[k] && v.valid[k]) begin
                    b.data = v.din[k];
                    b.idx  = 2'(k);
                    b.last = v.last[k];
                    sb.push_back(b);
                end
            end
        end
    endtask

    // Sample mid-cycle: score any output transfer and check ready/valid.
    task automatic checkOutput(input vec_t v, input string tag);
        beat_t b;
        #3;
        if (o_valid && o_ready) begin
            if (sb.size() == 0) begin
                vec_count++;
                miscompares++;
                $display("[TB] FAIL %s unexpected beat: got data %0h idx %0d, want none", tag, o_data, o_idx);
            end else begin
                b = sb.pop_front();
                check({tag, " beat data"}, 32'(o_data), 32'(b.data));
                check({tag, " beat idx"}, 32'(o_idx), 32'(b.idx));
                check({tag, " beat last"}, 32'(o_last), 32'(b.last));
            end
        end
        check({tag, " i_ready"}, 32'(i_ready), 32'(v.exp_ready));
        check({tag, " o_valid"}, 32'(o_valid), 32'(v.exp_ovalid));
        if (v.chk_data) begin
            check({tag, " o_data hold"}, 32'(o_data), 32'(v.exp_data));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [5:0] w_valid [7];
        logic [5:0] w_ready [7];
        logic [2:0] w_idx   [7];
        logic       w_ov    [7];

        arst_n = 1'b0;
        v6     = '0;
        l6     = '0;
        ordy6  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d6[k] = 8'h60 + 8'(k);
        end

        // Reset state with every source requesting.
        v = mk(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0);
        applyStimulus(v);
        checkOutput(v, "reset");
        check("reset o_data", 32'(o_data), 32'h0);
        check("reset o_idx", 32'(o_idx), 32'h0);
        check("reset o_last", 32'(o_last), 32'h0);
        applyStimulus(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        @(negedge clk);
        arst_n = 1'b1;
        step();

        // Start a packet on input 2, then reset while it is locked.
        v = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0);
        applyStimulus(v);
        checkOutput(v, "pre-reset first beat");
        step();
        v = mk(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1);
        v.discard = 1'b1;
        applyStimulus(v);
        checkOutput(v, "pre-reset locked");
        #1 arst_n = 1'b0;
        #1;
        check("mid reset o_valid", 32'(o_valid), 32'h0);
        check("mid reset i_ready", 32'(i_ready), 32'h0);
        check("mid reset o_idx", 32'(o_idx), 32'h0);
        applyStimulus(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));
        step();
        @(negedge clk);
        arst_n = 1'b1;
        step();

        // Post-reset: no residual lock, pointer back at 0.
        vecs.push_back(mk(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b0));
        vecs.push_back(mk(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1));
        // Fairness: all sources valid with single-beat packets.
        vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1));
        vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1));
        vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1));
        // Packet lock: three-beat packet on input 1 while input 2 waits.
        v = mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b0); v.din[1] = 8'hA1; vecs.push_back(v);
        v = mk(4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1); v.din[1] = 8'hA2; vecs.push_back(v);
        v = mk(4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1); v.din[1] = 8'hA3; vecs.push_back(v);
        vecs.push_back(mk(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1));
        // Backpressure: 8'h55 held for five stalled cycles, then no bubble.
        v = mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0); v.din[0] = 8'h55; vecs.push_back(v);
        for (int c = 0; c < 5; c++) begin
            v = mk(4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b1);
            v.din[0] = 8'h66; v.chk_data = 1'b1; v.exp_data = 8'h55;
            vecs.push_back(v);
        end
        v = mk(4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1);
        v.din[0] = 8'h66; v.chk_data = 1'b1; v.exp_data = 8'h55;
        vecs.push_back(v);
        v = mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1); v.din[0] = 8'h66; vecs.push_back(v);
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1));
        // Lock holds while the owner idles; input 0 must wait.
        vecs.push_back(mk(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0));
        vecs.push_back(mk(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0));

        for (int r = 0; r < vecs.size(); r++) begin
            applyStimulus(vecs[r]);
            checkOutput(vecs[r], $sformatf("vec%0d", r));
            step();
        end
        check("scoreboard drained", 32'(sb.size()), 32'h0);

        // Six-input wrap-around: input 4 first moves the pointer to 5.
        w_valid = '{6'b010000, 6'b100001, 6'b100001, 6'b100001, 6'b100001, 6'b000000, 6'b000000};
        w_ready = '{6'b010000, 6'b100000, 6'b000001, 6'b100000, 6'b000001, 6'b000000, 6'b000000};
        w_idx   = '{3'd0, 3'd4, 3'd5, 3'd0, 3'd5, 3'd0, 3'd0};
        w_ov    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int r = 0; r < 7; r++) begin
            v6 = w_valid[r];
            l6 = w_valid[r];
            #3;
            check($sformatf("wrap%0d i_ready", r), 32'(r6), 32'(w_ready[r]));
            check($sformatf("wrap%0d o_valid", r), 32'(ov6), 32'(w_ov[r]));
            if (w_ov[r]) begin
                check($sformatf("wrap%0d o_idx", r), 32'(oi6), 32'(w_idx[r]));
                check($sformatf("wrap%0d o_data", r), 32'(od6), 32'(8'h60 + 8'(w_idx[r])));
                check($sformatf("wrap%0d o_idx range", r), 32'(oi6 <= 3'd5), 32'h1);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
